// File: rtl/monitor_contador16_if.sv
// Signal bundle between contador_de16_bits (and its drivers) and the monitor.
// The master side drives the counter's controls and outputs; the slave side is the checker.
interface monitor_contador16_if #(
    parameter int CNT_W = 8
);
    logic             ENB;
    logic [1:0]       MODO;
    logic [15:0]      D;
    logic [15:0]      Q;
    logic             RCO;
    logic             Paridad;
    logic             CLR;
    logic             VALID;
    logic             ERR_SEQ;
    logic             ERR_PAR;
    logic [CNT_W-1:0] CNT_RCO;
    logic [15:0]      Q_ESPERADO;

    modport master (
        output ENB, MODO, D, Q, RCO, Paridad, CLR,
        input  VALID, ERR_SEQ, ERR_PAR, CNT_RCO, Q_ESPERADO
    );

    modport slave (
        input  ENB, MODO, D, Q, RCO, Paridad, CLR,
        output VALID, ERR_SEQ, ERR_PAR, CNT_RCO, Q_ESPERADO
    );
endinterface

// File: rtl/monitor_contador16.sv
// Checker for contador_de16_bits: predicts each Q from the previous cycle's controls,
// verifies parity, counts RCO pulses and raises sticky error flags.
module monitor_contador16 #(
    parameter bit PAR_IMPAR = 1'b0,
    parameter int CNT_W     = 8
) (
    input  logic                 CLK,
    input  logic                 RST_N,
    monitor_contador16_if.slave  mon
);
    typedef enum logic [1:0] {INICIO, SEGUIR, FALLA} estado_t;

    estado_t          state_reg, state_next;
    logic [15:0]      q_prev_reg, d_prev_reg;
    logic [1:0]       modo_prev_reg;
    logic             enb_prev_reg;
    logic             valid_reg;
    logic             err_seq_reg, err_seq_next;
    logic             err_par_reg, err_par_next;
    logic [CNT_W-1:0] cnt_rco_reg, cnt_rco_next;
    logic [15:0]      q_esperado_reg;
    logic [15:0]      pred_actual, pred_siguiente;
    logic             par_ok;

    function automatic logic [15:0] predecir(input logic enb, input logic [1:0] modo,
                                             input logic [15:0] q, input logic [15:0] d);
        if (!enb)
            return q;
        case (modo)
            2'b00:   return q + 16'd1;
            2'b01:   return q - 16'd1;
            2'b10:   return q - 16'd3;
            default: return d;
        endcase
    endfunction

    // Prediction for the Q sampled now, and for the Q that will be sampled next edge.
    assign pred_actual    = predecir(enb_prev_reg, modo_prev_reg, q_prev_reg, d_prev_reg);
    assign pred_siguiente = predecir(mon.ENB, mon.MODO, mon.Q, mon.D);
    assign par_ok         = (mon.Paridad == ((^mon.Q) ^ PAR_IMPAR));

    always_comb begin
        state_next   = state_reg;
        err_seq_next = err_seq_reg;
        err_par_next = err_par_reg;
        cnt_rco_next = cnt_rco_reg;
        if (mon.CLR) begin
            // CLR outranks any error or RCO event on the same edge.
            err_seq_next = 1'b0;
            err_par_next = 1'b0;
            cnt_rco_next = '0;
            state_next   = SEGUIR;
        end else begin
            case (state_reg)
                INICIO: state_next = SEGUIR;
                SEGUIR, FALLA: begin
                    if (state_reg == SEGUIR && mon.Q != pred_actual) begin
                        err_seq_next = 1'b1;
                        state_next   = FALLA;
                    end
                    if (!par_ok)
                        err_par_next = 1'b1;
                    if (mon.RCO && enb_prev_reg && cnt_rco_reg != '1)
                        cnt_rco_next = cnt_rco_reg + CNT_W'(1);
                end
                default: state_next = INICIO;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_reg      <= INICIO;
            q_prev_reg     <= '0;
            d_prev_reg     <= '0;
            modo_prev_reg  <= '0;
            enb_prev_reg   <= 1'b0;
            valid_reg      <= 1'b0;
            err_seq_reg    <= 1'b0;
            err_par_reg    <= 1'b0;
            cnt_rco_reg    <= '0;
            q_esperado_reg <= '0;
        end else begin
            state_reg      <= state_next;
            q_prev_reg     <= mon.Q;
            d_prev_reg     <= mon.D;
            modo_prev_reg  <= mon.MODO;
            enb_prev_reg   <= mon.ENB;
            valid_reg      <= 1'b1;
            err_seq_reg    <= err_seq_next;
            err_par_reg    <= err_par_next;
            cnt_rco_reg    <= cnt_rco_next;
            q_esperado_reg <= pred_siguiente;
        end
    end

    assign mon.VALID      = valid_reg;
    assign mon.ERR_SEQ    = err_seq_reg;
    assign mon.ERR_PAR    = err_par_reg;
    assign mon.CNT_RCO    = cnt_rco_reg;
    assign mon.Q_ESPERADO = q_esperado_reg;
endmodule

// File: tb/tb_monitor_contador16.sv
// Directed bench for monitor_contador16: one instance per parity convention,
// both fed the same counter stimulus.
module tb_monitor_contador16;
    logic CLK = 1'b0;
    logic RST_N = 1'b0;
    int   total = 0;
    int   passed = 0;
    logic [15:0] qv;

    always #5 CLK = ~CLK;

    monitor_contador16_if #(.CNT_W(8)) if0 ();
    monitor_contador16_if #(.CNT_W(8)) if1 ();

    assign if1.ENB     = if0.ENB;
    assign if1.MODO    = if0.MODO;
    assign if1.D       = if0.D;
    assign if1.Q       = if0.Q;
    assign if1.RCO     = if0.RCO;
    assign if1.Paridad = if0.Paridad;
    assign if1.CLR     = if0.CLR;

    monitor_contador16 #(.PAR_IMPAR(1'b0), .CNT_W(8)) dut0 (.CLK(CLK), .RST_N(RST_N), .mon(if0));
    monitor_contador16 #(.PAR_IMPAR(1'b1), .CNT_W(8)) dut1 (.CLK(CLK), .RST_N(RST_N), .mon(if1));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // par_bad inverts the even-parity bit so dut0 sees a parity fault.
    task automatic step(input logic enb, input logic [1:0] modo, input logic [15:0] d,
                        input logic [15:0] q, input logic rco, input logic par_bad,
                        input logic clr);
        if0.ENB     = enb;
        if0.MODO    = modo;
        if0.D       = d;
        if0.Q       = q;
        if0.RCO     = rco;
        if0.Paridad = (^q) ^ par_bad;
        if0.CLR     = clr;
        @(posedge CLK);
        #1;
    endtask

    initial begin
        if0.ENB = 1'b1; if0.MODO = 2'b00; if0.D = '0; if0.Q = '0;
        if0.RCO = 1'b0; if0.Paridad = 1'b0; if0.CLR = 1'b0;
        #7;
        chk("rst_valid", 32'(if0.VALID), 32'd0);
        chk("rst_err_seq", 32'(if0.ERR_SEQ), 32'd0);
        chk("rst_err_par", 32'(if0.ERR_PAR), 32'd0);
        chk("rst_cnt", 32'(if0.CNT_RCO), 32'd0);
        chk("rst_qe", 32'(if0.Q_ESPERADO), 32'h0);
        #1 RST_N = 1'b1;

        // Free-running up count from 0000.
        for (int i = 0; i < 20; i++) begin
            step(1'b1, 2'b00, 16'h0, 16'(i), 1'b0, 1'b0, 1'b0);
            chk("run_valid", 32'(if0.VALID), 32'd1);
            chk("run_err_seq", 32'(if0.ERR_SEQ), 32'd0);
            chk("run_err_par", 32'(if0.ERR_PAR), 32'd0);
            chk("run_qe", 32'(if0.Q_ESPERADO), 32'(i + 1));
        end

        // Load FFFD and wrap through 0000.
        step(1'b1, 2'b11, 16'hFFFD, 16'd20, 1'b0, 1'b0, 1'b0);
        chk("load_qe", 32'(if0.Q_ESPERADO), 32'hFFFD);
        step(1'b1, 2'b00, 16'h0, 16'hFFFD, 1'b0, 1'b0, 1'b0);
        chk("wrap_qe0", 32'(if0.Q_ESPERADO), 32'hFFFE);
        step(1'b1, 2'b00, 16'h0, 16'hFFFE, 1'b0, 1'b0, 1'b0);
        chk("wrap_qe1", 32'(if0.Q_ESPERADO), 32'hFFFF);
        step(1'b1, 2'b00, 16'h0, 16'hFFFF, 1'b1, 1'b0, 1'b0);
        chk("wrap_qe2", 32'(if0.Q_ESPERADO), 32'h0000);
        chk("wrap_cnt", 32'(if0.CNT_RCO), 32'd1);
        step(1'b1, 2'b00, 16'h0, 16'h0000, 1'b0, 1'b0, 1'b0);
        chk("wrap_qe3", 32'(if0.Q_ESPERADO), 32'h0001);
        step(1'b1, 2'b00, 16'h0, 16'h0001, 1'b0, 1'b0, 1'b0);
        chk("wrap_err_seq", 32'(if0.ERR_SEQ), 32'd0);
        chk("wrap_cnt_hold", 32'(if0.CNT_RCO), 32'd1);

        // Descending by 3 across zero, then a forced sequence fault.
        step(1'b1, 2'b10, 16'h0, 16'h0002, 1'b0, 1'b0, 1'b0);
        chk("dn3_qe0", 32'(if0.Q_ESPERADO), 32'hFFFF);
        step(1'b1, 2'b10, 16'h0, 16'hFFFF, 1'b0, 1'b0, 1'b0);
        chk("dn3_qe1", 32'(if0.Q_ESPERADO), 32'hFFFC);
        chk("dn3_ok", 32'(if0.ERR_SEQ), 32'd0);
        step(1'b1, 2'b10, 16'h0, 16'hFFFB, 1'b0, 1'b0, 1'b0);
        chk("dn3_fault", 32'(if0.ERR_SEQ), 32'd1);
        chk("dn3_resync_qe", 32'(if0.Q_ESPERADO), 32'hFFF8);
        step(1'b1, 2'b10, 16'h0, 16'hFFF8, 1'b0, 1'b0, 1'b0);
        chk("falla_sticky", 32'(if0.ERR_SEQ), 32'd1);
        step(1'b1, 2'b10, 16'h0, 16'hFFF5, 1'b0, 1'b0, 1'b1);
        chk("clr_err_seq", 32'(if0.ERR_SEQ), 32'd0);
        chk("clr_cnt", 32'(if0.CNT_RCO), 32'd0);
        step(1'b1, 2'b10, 16'h0, 16'hFFF2, 1'b0, 1'b0, 1'b0);
        chk("seguir_ok", 32'(if0.ERR_SEQ), 32'd0);
        chk("seguir_qe", 32'(if0.Q_ESPERADO), 32'hFFEF);
        step(1'b1, 2'b10, 16'h0, 16'h1234, 1'b0, 1'b0, 1'b0);
        chk("seguir_fault", 32'(if0.ERR_SEQ), 32'd1);
        // Mismatch and CLR on the same edge: CLR wins.
        step(1'b1, 2'b11, 16'h0003, 16'h5555, 1'b0, 1'b0, 1'b1);
        chk("clr_prio_seq", 32'(if0.ERR_SEQ), 32'd0);
        chk("clr_qe", 32'(if0.Q_ESPERADO), 32'h0003);
        chk("clr_dut1_par", 32'(if1.ERR_PAR), 32'd0);

        // Q=0003 with Paridad=1: fault for even convention, fine for odd.
        step(1'b1, 2'b00, 16'h0, 16'h0003, 1'b0, 1'b1, 1'b0);
        chk("par_fault", 32'(if0.ERR_PAR), 32'd1);
        chk("par_seq_clean", 32'(if0.ERR_SEQ), 32'd0);
        chk("par_odd_ok", 32'(if1.ERR_PAR), 32'd0);
        step(1'b1, 2'b00, 16'h0, 16'h0004, 1'b0, 1'b0, 1'b0);
        chk("par_sticky", 32'(if0.ERR_PAR), 32'd1);
        chk("par_qe", 32'(if0.Q_ESPERADO), 32'h0005);

        // RCO saturation.
        step(1'b1, 2'b00, 16'h0, 16'h0005, 1'b0, 1'b0, 1'b1);
        chk("clr_par", 32'(if0.ERR_PAR), 32'd0);
        chk("clr_cnt2", 32'(if0.CNT_RCO), 32'd0);
        for (int i = 0; i < 300; i++) begin
            step(1'b1, 2'b00, 16'h0, 16'(6 + i), 1'b1, 1'b0, 1'b0);
            if (i == 99)  chk("cnt_100", 32'(if0.CNT_RCO), 32'd100);
            if (i == 254) chk("cnt_255", 32'(if0.CNT_RCO), 32'hFF);
        end
        chk("cnt_sat", 32'(if0.CNT_RCO), 32'hFF);
        chk("sat_err_seq", 32'(if0.ERR_SEQ), 32'd0);
        step(1'b1, 2'b00, 16'h0, 16'h0132, 1'b1, 1'b0, 1'b1);
        chk("clr_prio_cnt", 32'(if0.CNT_RCO), 32'd0);
        step(1'b1, 2'b00, 16'h0, 16'h0133, 1'b1, 1'b0, 1'b0);
        chk("cnt_after_clr", 32'(if0.CNT_RCO), 32'd1);
        step(1'b0, 2'b00, 16'h0, 16'h0134, 1'b0, 1'b0, 1'b0);
        chk("hold_qe", 32'(if0.Q_ESPERADO), 32'h0134);
        // RCO after a disabled cycle is not counted.
        step(1'b1, 2'b00, 16'h0, 16'h0134, 1'b1, 1'b0, 1'b0);
        chk("rco_enb_prev0", 32'(if0.CNT_RCO), 32'd1);
        chk("hold_seq", 32'(if0.ERR_SEQ), 32'd0);
        step(1'b1, 2'b00, 16'h0, 16'h0135, 1'b1, 1'b0, 1'b0);
        chk("rco_enb_prev1", 32'(if0.CNT_RCO), 32'd2);

        // Reset mid-cycle while ERR_SEQ is set.
        qv = 16'h9999;
        step(1'b1, 2'b00, 16'h0, qv, 1'b0, 1'b0, 1'b0);
        chk("pre_rst_seq", 32'(if0.ERR_SEQ), 32'd1);
        #2 RST_N = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(if0.VALID), 32'd0);
        chk("mid_rst_seq", 32'(if0.ERR_SEQ), 32'd0);
        chk("mid_rst_cnt", 32'(if0.CNT_RCO), 32'd0);
        chk("mid_rst_qe", 32'(if0.Q_ESPERADO), 32'h0);
        #1 RST_N = 1'b1;
        step(1'b1, 2'b00, 16'h0, 16'h0000, 1'b0, 1'b0, 1'b0);
        chk("rearm_valid", 32'(if0.VALID), 32'd1);
        chk("rearm_seq", 32'(if0.ERR_SEQ), 32'd0);
        chk("rearm_qe", 32'(if0.Q_ESPERADO), 32'h0001);
        step(1'b1, 2'b00, 16'h0, 16'h0001, 1'b0, 1'b0, 1'b0);
        chk("rearm_seq2", 32'(if0.ERR_SEQ), 32'd0);
        chk("rearm_par", 32'(if0.ERR_PAR), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
